symbol_packer: RTL and testbench

Receive-side stage directly downstream of the depacketizer. It consumes the payload symbol stream: one 2-bit QPSK or 1-bit BPSK symbol per valid beat, with a per-beat modulation flag and a last-symbol marker. It packs the symbol bits MSB-first into bytes, zero-pads the final partial byte of a packet, and presents the bytes on an AXI-Stream master through a small FIFO. The upstream stage cannot be back-pressured, so the FIFO absorbs downstream stalls and reports drops.

---
 rtl/rx_pkg.sv | 20 ++
 rtl/symbol_packer_if.sv | 27 ++
 rtl/symbol_packer_byte_fifo.sv | 45 ++++
 rtl/symbol_packer.sv | 111 +++++++++++
 tb/tb_symbol_packer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared receive-path constants and types for the symbol packer and its FIFO.
package rx_pkg;

  localparam logic MOD_BPSK = 1'b1;
  localparam logic MOD_QPSK = 1'b0;

  localparam int BITS_PER_BYTE = 8;
  localparam int FIFO_WIDTH    = BITS_PER_BYTE + 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

  // Move n right-aligned accumulated bits up to the MSBs, zero-filling the LSBs.
  function automatic logic [7:0] left_align(input logic [7:0] bits, input logic [3:0] n);
    return bits << (4'(BITS_PER_BYTE) - n);
  endfunction

endpackage

// File: rtl/symbol_packer_if.sv
// Symbol-in / byte-out stream bundle of the symbol packer.
interface symbol_packer_if;

  logic [1:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic       s_tuser;

  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  // Environment side: feeds symbols, accepts bytes.
  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

  // Packer side.
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/symbol_packer_byte_fifo.sv
// Synchronous FIFO with fall-through head; pointers carry an extra wrap bit.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/symbol_packer.sv
// Packs QPSK/BPSK payload symbols MSB-first into bytes and queues them on a
// non-back-pressuring path; drops on a full FIFO are flagged sticky.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for the first beat of a packet; s_tuser is latched
// ST_PKT  | packet in progress; mode_lat governs bits per beat
module symbol_packer
  import rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  symbol_packer_if.slave       bus,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] byte_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [0:0] state;
  logic       mode_lat;
  logic [7:0] acc;
  logic [3:0] nbits;

  logic       mode_eff;
  logic [7:0] acc_nxt;
  logic [3:0] nbits_nxt;
  logic       byte_done;
  logic       push_req;
  fifo_word_t push_word;

  logic       pop;
  logic       push_ok;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  fifo_word_t head;

  always_comb begin
    mode_eff = (state == ST_PKT) ? mode_lat : bus.s_tuser;
    if (mode_eff == MOD_BPSK) begin
      acc_nxt   = (acc << 1) | 8'(bus.s_tdata[1]);
      nbits_nxt = nbits + 4'd1;
    end else begin
      acc_nxt   = (acc << 2) | 8'(bus.s_tdata);
      nbits_nxt = nbits + 4'd2;
    end
    byte_done      = (nbits_nxt == 4'(BITS_PER_BYTE));
    push_req       = bus.s_tvalid && (byte_done || bus.s_tlast);
    push_word.last = bus.s_tlast;
    push_word.data = left_align(acc_nxt, nbits_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_lat <= MOD_BPSK;
      acc      <= '0;
      nbits    <= '0;
    end else if (bus.s_tvalid) begin
      if (state == ST_IDLE) mode_lat <= bus.s_tuser;
      if (bus.s_tlast || byte_done) begin
        acc   <= '0;
        nbits <= '0;
      end else begin
        acc   <= acc_nxt;
        nbits <= nbits_nxt;
      end
      state <= bus.s_tlast ? ST_IDLE : ST_PKT;
    end
  end

  assign pop     = !fifo_empty && bus.m_tready;
  assign push_ok = push_req && (!fifo_full || pop);
  // The packer keeps advancing on a drop; only the byte itself is lost.
  assign drop    = push_req && fifo_full && !pop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (drop)    overflow   <= 1'b1;
      if (push_ok) byte_count <= byte_count + CNT_WIDTH'(1);
    end
  end

  assign bus.s_tready = 1'b1;
  assign bus.m_tvalid = !fifo_empty;
  assign bus.m_tdata  = fifo_empty ? 8'h00 : head.data;
  assign bus.m_tlast  = !fifo_empty && head.last;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: packing, flush, mode latch, overflow, reset, count wrap.
module tb_symbol_packer;

  logic clk = 1'b0;
  logic rst;
  logic overflow;
  logic [3:0] byte_count;

  always #5 clk = ~clk;

  symbol_packer_if sp_if ();

  symbol_packer #(
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (sp_if),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] rxq [$];

  always @(posedge clk)
    if (!rst && sp_if.m_tvalid && sp_if.m_tready)
      rxq.push_back({sp_if.m_tlast, sp_if.m_tdata});

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sp_if.s_tvalid = 1'b0; sp_if.s_tdata = 2'b00; sp_if.s_tlast = 1'b0;
    sp_if.s_tuser = 1'b0; sp_if.m_tready = 1'b1;
    idle(2);
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic beat(input logic [1:0] d, input logic u, input logic l);
    sp_if.s_tvalid = 1'b1; sp_if.s_tdata = d; sp_if.s_tuser = u; sp_if.s_tlast = l;
    idle(1);
    sp_if.s_tvalid = 1'b0; sp_if.s_tlast = 1'b0;
  endtask

  task automatic qpsk_byte(input logic [7:0] b, input logic l);
    beat(b[7:6], 1'b0, 1'b0);
    beat(b[5:4], 1'b0, 1'b0);
    beat(b[3:2], 1'b0, 1'b0);
    beat(b[1:0], 1'b0, l);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sp_if.m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", sp_if.m_tvalid); end
    total++; if (sp_if.m_tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata got=%h want=00", sp_if.m_tdata); end
    total++; if (sp_if.m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", sp_if.m_tlast); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    total++; if (byte_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", byte_count); end
    total++; if (sp_if.s_tready !== 1'b1) begin bad++; $display("FAIL rst_tready got=%b want=1", sp_if.s_tready); end
  endtask

  task automatic test_qpsk();
    logic [8:0] exp [2];
    exp = '{9'h06C, 9'h11B};
    do_reset();
    beat(2'b01, 1'b0, 1'b0); beat(2'b10, 1'b0, 1'b0); beat(2'b11, 1'b0, 1'b0);
    beat(2'b00, 1'b0, 1'b0);
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b0, 8'h6C}) begin
      bad++; $display("FAIL qpsk_lat0 got=%b/%b/%h want=1/0/6c", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    beat(2'b00, 1'b0, 1'b0); beat(2'b01, 1'b0, 1'b0); beat(2'b10, 1'b0, 1'b0);
    beat(2'b11, 1'b0, 1'b1);
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b1, 8'h1B}) begin
      bad++; $display("FAIL qpsk_lat1 got=%b/%b/%h want=1/1/1b", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    idle(3);
    total++; if (byte_count !== 4'd2) begin bad++; $display("FAIL qpsk_count got=%0d want=2", byte_count); end
    total++; if (rxq.size() != 2) begin bad++; $display("FAIL qpsk_nbytes got=%0d want=2", rxq.size()); end
    for (int i = 0; i < 2 && i < rxq.size(); i++) begin
      total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL qpsk_byte%0d got=%h want=%h", i, rxq[i], exp[i]); end
    end
  endtask

  task automatic test_bpsk();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    do_reset();
    for (int i = 7; i >= 0; i--) beat({bits[i], bits[i]}, 1'b1, i == 0);
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b1, 8'hB2}) begin
      bad++; $display("FAIL bpsk_head got=%b/%b/%h want=1/1/b2", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    idle(3);
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL bpsk_nbytes got=%0d want=1", rxq.size()); end
    else begin
      total++; if (rxq[0] !== 9'h1B2) begin bad++; $display("FAIL bpsk_byte got=%h want=1b2", rxq[0]); end
    end
  endtask

  task automatic test_bpsk_flush();
    logic [10:0] bits;
    logic [8:0] exp [2];
    bits = 11'b1111_0000_101;
    exp = '{9'h0F0, 9'h1A0};
    do_reset();
    for (int i = 10; i >= 0; i--) beat({bits[i], bits[i]}, 1'b1, i == 0);
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b1, 8'hA0}) begin
      bad++; $display("FAIL flush_head got=%b/%b/%h want=1/1/a0", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    idle(3);
    total++; if (rxq.size() != 2) begin bad++; $display("FAIL flush_nbytes got=%0d want=2", rxq.size()); end
    for (int i = 0; i < 2 && i < rxq.size(); i++) begin
      total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL flush_byte%0d got=%h want=%h", i, rxq[i], exp[i]); end
    end
  endtask

  task automatic test_mode_toggle();
    logic [1:0] d [8];
    logic [8:0] exp [2];
    d = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{9'h06C, 9'h11B};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beat(d[i], i[0], i == 7);
      if (i == 1 || i == 3 || i == 4) begin
        // invalid beat carrying junk, including a spurious last
        sp_if.s_tvalid = 1'b0; sp_if.s_tdata = 2'b11; sp_if.s_tlast = 1'b1; sp_if.s_tuser = ~i[0];
        idle(2);
        sp_if.s_tlast = 1'b0;
      end
    end
    idle(3);
    total++; if (byte_count !== 4'd2) begin bad++; $display("FAIL toggle_count got=%0d want=2", byte_count); end
    total++; if (rxq.size() != 2) begin bad++; $display("FAIL toggle_nbytes got=%0d want=2", rxq.size()); end
    for (int i = 0; i < 2 && i < rxq.size(); i++) begin
      total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL toggle_byte%0d got=%h want=%h", i, rxq[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] exp [4];
    exp = '{9'h011, 9'h022, 9'h033, 9'h044};
    do_reset();
    sp_if.m_tready = 1'b0;
    qpsk_byte(8'h11, 1'b0); qpsk_byte(8'h22, 1'b0); qpsk_byte(8'h33, 1'b0); qpsk_byte(8'h44, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_noflag got=%b want=0", overflow); end
    total++; if (byte_count !== 4'd4) begin bad++; $display("FAIL ovf_count4 got=%0d want=4", byte_count); end
    qpsk_byte(8'h55, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (byte_count !== 4'd4) begin bad++; $display("FAIL ovf_count_drop got=%0d want=4", byte_count); end
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b0, 8'h11}) begin
      bad++; $display("FAIL ovf_head_stable got=%b/%b/%h want=1/0/11", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    sp_if.m_tready = 1'b1;
    idle(6);
    total++; if (rxq.size() != 4) begin bad++; $display("FAIL ovf_nbytes got=%0d want=4", rxq.size()); end
    for (int i = 0; i < 4 && i < rxq.size(); i++) begin
      total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL ovf_byte%0d got=%h want=%h", i, rxq[i], exp[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    total++; if (sp_if.m_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", sp_if.m_tvalid); end
  endtask

  task automatic test_full_pop();
    logic [8:0] exp [5];
    exp = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h15C};
    do_reset();
    sp_if.m_tready = 1'b0;
    qpsk_byte(8'hA1, 1'b0); qpsk_byte(8'hA2, 1'b0); qpsk_byte(8'hA3, 1'b0); qpsk_byte(8'hA4, 1'b0);
    beat(2'b01, 1'b0, 1'b0); beat(2'b01, 1'b0, 1'b0); beat(2'b11, 1'b0, 1'b0);
    sp_if.m_tready = 1'b1;
    beat(2'b00, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow got=%b want=0", overflow); end
    total++; if (byte_count !== 4'd5) begin bad++; $display("FAIL fullpop_count got=%0d want=5", byte_count); end
    idle(8);
    total++; if (rxq.size() != 5) begin bad++; $display("FAIL fullpop_nbytes got=%0d want=5", rxq.size()); end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL fullpop_byte%0d got=%h want=%h", i, rxq[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sp_if.m_tready = 1'b0;
    qpsk_byte(8'h77, 1'b0);
    beat(2'b11, 1'b0, 1'b0); beat(2'b01, 1'b0, 1'b0); beat(2'b10, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rxq.delete();
    total++; if (sp_if.m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_fifo_empty got=%b want=0", sp_if.m_tvalid); end
    sp_if.m_tready = 1'b1;
    qpsk_byte(8'hFF, 1'b1);
    total++; if ({sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata} !== {1'b1, 1'b1, 8'hFF}) begin
      bad++; $display("FAIL mid_head got=%b/%b/%h want=1/1/ff", sp_if.m_tvalid, sp_if.m_tlast, sp_if.m_tdata); end
    idle(3);
    total++; if (byte_count !== 4'd1) begin bad++; $display("FAIL mid_count got=%0d want=1", byte_count); end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL mid_nbytes got=%0d want=1", rxq.size()); end
    else begin
      total++; if (rxq[0] !== 9'h1FF) begin bad++; $display("FAIL mid_byte got=%h want=1ff", rxq[0]); end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) qpsk_byte(8'(i), 1'b0);
    total++; if (byte_count !== 4'd15) begin bad++; $display("FAIL wrap_count15 got=%0d want=15", byte_count); end
    qpsk_byte(8'h0F, 1'b0);
    total++; if (byte_count !== 4'd0) begin bad++; $display("FAIL wrap_count0 got=%0d want=0", byte_count); end
    qpsk_byte(8'h10, 1'b1);
    total++; if (byte_count !== 4'd1) begin bad++; $display("FAIL wrap_count1 got=%0d want=1", byte_count); end
    idle(3);
    total++; if (rxq.size() != 17) begin bad++; $display("FAIL wrap_nbytes got=%0d want=17", rxq.size()); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%b want=0", overflow); end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_bpsk();
    test_bpsk_flush();
    test_mode_toggle();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
